// File: rtl/bd_sync_strobe.sv
// bd_sync_strobe: synchronous replacement for a BDx delay-chain pulse former.
// Produces a CE-cycle delayed copy of inpt (outpt) and a fixed-width strobe
// on selected edges of that copy, plus a wrapping count of accepted edges.
// Optional input glitch filter: define BD_GLITCH_FILTER_EN.
module bd_sync_strobe #(
   parameter int unsigned DELAY    = 3,
   parameter int unsigned WIDTH    = 2,
   parameter int unsigned EDGE     = 0,
   parameter int unsigned FILT_LEN = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       inpt,
   output logic       outpt,
   output logic       strobe,
   output logic [7:0] edge_cnt
);

   // Configuration range checks, resolved at elaboration.
   if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
      $error("bd_sync_strobe: DELAY must be 1..16");
   end
   if (WIDTH < 1 || WIDTH > 15) begin : g_bad_width
      $error("bd_sync_strobe: WIDTH must be 1..15");
   end
   if (EDGE > 3) begin : g_bad_edge
      $error("bd_sync_strobe: EDGE must be 0..3");
   end
   if (FILT_LEN < 1 || FILT_LEN > 15) begin : g_bad_filt
      $error("bd_sync_strobe: FILT_LEN must be 1..15");
   end

   localparam logic [3:0] WC_INIT = 4'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   logic             src;
   logic [DELAY-1:0] sh;
   logic [DELAY-1:0] sh_d;
   logic             nxt;
   logic             edge_hit;
   logic [3:0]       wc;
   state_t           state;

`ifdef BD_GLITCH_FILTER_EN
   localparam logic [3:0] RUN_LAST = 4'(FILT_LEN - 1);

   logic       src_q;
   logic [3:0] run;

   // Glitch filter: adopt inpt only after it disagrees with src for FILT_LEN CE cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         src_q <= 1'b0;
         run   <= '0;
      end else if (ce) begin
         if (inpt == src_q) begin
            run <= '0;
         end else if (run == RUN_LAST) begin
            src_q <= inpt;
            run   <= '0;
         end else begin
            run <= run + 4'd1;
         end
      end
   end

   assign src = src_q;
`else
   assign src = inpt;
`endif

   // nxt is the value outpt takes on the next CE edge; with a one-stage line
   // that is src itself, so the edge is seen on the same edge outpt moves.
   if (DELAY == 1) begin : g_d1
      assign nxt  = src;
      assign sh_d = src;
   end else begin : g_dn
      assign nxt  = sh[DELAY-2];
      assign sh_d = {sh[DELAY-2:0], src};
   end

   assign outpt    = sh[DELAY-1];
   assign edge_hit = (nxt != sh[DELAY-1]) &&
                     ((EDGE == 0) ? nxt : (EDGE == 1) ? !nxt : 1'b1);

   // Delay line, strobe FSM and edge counter, all advancing on CE edges only.
   always_ff @(posedge clk) begin
      if (reset) begin
         sh       <= '0;
         state    <= S_IDLE;
         wc       <= '0;
         strobe   <= 1'b0;
         edge_cnt <= '0;
      end else if (ce) begin
         sh <= sh_d;
         if (edge_hit) begin
            state    <= S_ACTIVE;
            wc       <= WC_INIT;
            strobe   <= 1'b1;
            edge_cnt <= edge_cnt + 8'd1;
         end else if (state == S_ACTIVE) begin
            if (wc != 4'd0) begin
               wc <= wc - 4'd1;
            end else begin
               state  <= S_IDLE;
               strobe <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_bd_sync_strobe.sv
// Self-checking bench for bd_sync_strobe: three parameterisations driven by
// shared stimulus, compared every cycle against a history-based model.
module tb_bd_sync_strobe;

   localparam int NI = 3;
   localparam int ND [NI] = '{3, 1, 5};
   localparam int NW [NI] = '{2, 4, 3};
   localparam int NE [NI] = '{0, 2, 1};
   localparam int FL = 2;
`ifdef BD_GLITCH_FILTER_EN
   localparam int FO = FL;
`else
   localparam int FO = 0;
`endif

   logic       clk = 1'b0;
   logic       reset, ce, inpt;
   logic       outpt  [NI];
   logic       strobe [NI];
   logic [7:0] edge_cnt [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bd_sync_strobe #(.DELAY(3), .WIDTH(2), .EDGE(0), .FILT_LEN(FL)) u_a (
      .clk(clk), .reset(reset), .ce(ce), .inpt(inpt),
      .outpt(outpt[0]), .strobe(strobe[0]), .edge_cnt(edge_cnt[0]));
   bd_sync_strobe #(.DELAY(1), .WIDTH(4), .EDGE(2), .FILT_LEN(FL)) u_b (
      .clk(clk), .reset(reset), .ce(ce), .inpt(inpt),
      .outpt(outpt[1]), .strobe(strobe[1]), .edge_cnt(edge_cnt[1]));
   bd_sync_strobe #(.DELAY(5), .WIDTH(3), .EDGE(1), .FILT_LEN(FL)) u_c (
      .clk(clk), .reset(reset), .ce(ce), .inpt(inpt),
      .outpt(outpt[2]), .strobe(strobe[2]), .edge_cnt(edge_cnt[2]));

   // Model: src value captured on each CE edge since reset; outputs derived from history.
   bit src_hist[$];
   bit in_hist[$];
   bit src_m;
   int acc_n   [NI];
   int last_acc[NI];

   function automatic bit out_at(int i, int n);
      int j;
      j = n - ND[i];
      return (j >= 0) ? src_hist[j] : 1'b0;
   endfunction

   task automatic model_edge(bit r, bit c, bit x);
      int n;
      bit o, p, all_diff;
      if (r) begin
         src_hist.delete();
         in_hist.delete();
         src_m = 1'b0;
         for (int i = 0; i < NI; i++) begin
            acc_n[i]    = 0;
            last_acc[i] = -1000;
         end
         return;
      end
      if (!c) return;
`ifdef BD_GLITCH_FILTER_EN
      src_hist.push_back(src_m);
      in_hist.push_back(x);
      if (in_hist.size() >= FL) begin
         all_diff = 1'b1;
         for (int k = in_hist.size() - FL; k < in_hist.size(); k++)
            if (in_hist[k] == src_m) all_diff = 1'b0;
         if (all_diff) src_m = x;
      end
`else
      src_hist.push_back(x);
`endif
      n = src_hist.size();
      for (int i = 0; i < NI; i++) begin
         o = out_at(i, n);
         p = out_at(i, n - 1);
         if (o != p && (NE[i] >= 2 || (NE[i] == 0 && o) || (NE[i] == 1 && !o))) begin
            acc_n[i]++;
            last_acc[i] = n;
         end
      end
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      int n;
      n = src_hist.size();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("outpt%0d", i), int'(outpt[i]), int'(out_at(i, n)));
         chk($sformatf("strobe%0d", i), int'(strobe[i]), int'((n - last_acc[i]) < NW[i]));
         chk($sformatf("edge_cnt%0d", i), int'(edge_cnt[i]), acc_n[i] % 256);
      end
   endtask

   // One clock: apply inputs, let the edge happen, advance model, compare after settling.
   task automatic step(bit r, bit c, bit x);
      reset = r;
      ce    = c;
      inpt  = x;
      @(posedge clk);
      model_edge(r, c, x);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      bit cur;
      reset = 1'b1; ce = 1'b0; inpt = 1'b0;

      // Reset state and basic propagation / strobe shapes.
      do_reset();
      chk("rst_outpt0", int'(outpt[0]), 0);
      chk("rst_cnt1", int'(edge_cnt[1]), 0);
      for (int e = 1; e <= 30; e++) begin
         step(1'b0, 1'b1, (e == 10 || e == 11));
         if (e == 11 + FO) chk("a_out_pre", int'(outpt[0]), 0);
         if (e == 12 + FO) chk("a_out_rise", int'(outpt[0]), 1);
         if (e == 12 + FO) chk("a_strb_first", int'(strobe[0]), 1);
         if (e == 13 + FO) chk("a_strb_last", int'(strobe[0]), 1);
         if (e == 14 + FO) chk("a_strb_end", int'(strobe[0]), 0);
         if (e == 14 + FO) chk("a_cnt", int'(edge_cnt[0]), 1);
         if (e == 15 + FO) chk("b_strb_retrig", int'(strobe[1]), 1);
         if (e == 16 + FO) chk("b_strb_end", int'(strobe[1]), 0);
         if (e == 16 + FO) chk("b_cnt", int'(edge_cnt[1]), 2);
         if (e == 15 + FO) chk("c_no_rise_strb", int'(strobe[2]), 0);
         if (e == 18 + FO) chk("c_strb_fall", int'(strobe[2]), 1);
         if (e == 19 + FO) chk("c_strb_end", int'(strobe[2]), 0);
         if (e == 19 + FO) chk("c_cnt", int'(edge_cnt[2]), 1);
      end

      // Alternating CE: timing measured in CE edges, values hold on CE=0.
      do_reset();
      for (int k = 1; k <= 14; k++) begin
         step(1'b0, (k % 2 == 1), 1'b1);
         if (k == 4 + 2 * FO) chk("ce_out_pre", int'(outpt[0]), 0);
         if (k == 5 + 2 * FO) chk("ce_out_rise", int'(outpt[0]), 1);
         if (k == 8 + 2 * FO) chk("ce_strb_hold", int'(strobe[0]), 1);
         if (k == 9 + 2 * FO) chk("ce_strb_end", int'(strobe[0]), 0);
      end

      // Reset with CE=0 in the middle of a strobe.
      do_reset();
      for (int k = 0; k < 2 + FO; k++) step(1'b0, 1'b1, 1'b1);
      chk("mid_strb", int'(strobe[1]), 1);
      step(1'b1, 1'b0, 1'b1);
      chk("rst_ce0_out", int'(outpt[1]), 0);
      chk("rst_ce0_strb", int'(strobe[1]), 0);
      chk("rst_ce0_cnt", int'(edge_cnt[1]), 0);

      // Single-cycle pulse: passes without filter, discarded with it.
      do_reset();
      for (int e = 1; e <= 10; e++) begin
         step(1'b0, 1'b1, (e == 3));
         if (e == 3) chk("glitch_out", int'(outpt[1]), (FO == 0) ? 1 : 0);
         if (e == 10) chk("glitch_cnt", int'(edge_cnt[1]), (FO == 0) ? 2 : 0);
      end

      // Randomised traffic with occasional reset and sparse CE.
      do_reset();
      cur = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0) cur = ~cur;
         step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), cur);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
